// File: rtl/dsp_simd_mac_lanes.sv
// SIMD multiply-accumulate array: LANES independent signed/unsigned MAC lanes behind one valid/ready stream.
// Define DSP_SIMD_MAC_SATURATE_EN to clamp out-of-range accumulations instead of wrapping them.
module dsp_simd_mac_lanes #(
  parameter int LANES           = 2,
  parameter int A_WIDTH         = 8,
  parameter int B_WIDTH         = 8,
  parameter int ACC_WIDTH       = 20,
  parameter int SHIFT_RIGHT     = 0,
  parameter int REGISTER_INPUTS = 1
) (
  input  logic                         clock_i,
  input  logic                         reset_n_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [LANES*A_WIDTH-1:0]     a_i,
  input  logic [LANES*B_WIDTH-1:0]     b_i,
  input  logic                         unsigned_a_i,
  input  logic                         unsigned_b_i,
  input  logic                         load_acc_i,
  input  logic                         subtract_i,
  input  logic                         clear_i,
  output logic [LANES*ACC_WIDTH-1:0]   z_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [LANES-1:0]             overflow_o
);

  localparam int PW = A_WIDTH + B_WIDTH + 2;
  localparam int RW = ACC_WIDTH + 2;

  if (ACC_WIDTH < A_WIDTH + B_WIDTH + 1) begin : g_width_check
    $error("dsp_simd_mac_lanes: ACC_WIDTH must be >= A_WIDTH+B_WIDTH+1");
  end

  // The whole pipeline freezes while a finished result is waiting for downstream.
  logic en;
  assign en      = ~(valid_o & ~ready_i);
  assign ready_o = en;

  logic                       s_valid;
  logic [LANES*A_WIDTH-1:0]   s_a;
  logic [LANES*B_WIDTH-1:0]   s_b;
  logic                       s_ua;
  logic                       s_ub;
  logic                       s_load;
  logic                       s_sub;

  if (REGISTER_INPUTS != 0) begin : g_inreg
    logic                     in_valid;
    logic [LANES*A_WIDTH-1:0] in_a;
    logic [LANES*B_WIDTH-1:0] in_b;
    logic                     in_ua;
    logic                     in_ub;
    logic                     in_load;
    logic                     in_sub;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        in_valid <= 1'b0;
        in_a     <= '0;
        in_b     <= '0;
        in_ua    <= 1'b0;
        in_ub    <= 1'b0;
        in_load  <= 1'b0;
        in_sub   <= 1'b0;
      end else if (en) begin
        in_valid <= valid_i;
        in_a     <= a_i;
        in_b     <= b_i;
        in_ua    <= unsigned_a_i;
        in_ub    <= unsigned_b_i;
        in_load  <= load_acc_i;
        in_sub   <= subtract_i;
      end
    end

    assign s_valid = in_valid;
    assign s_a     = in_a;
    assign s_b     = in_b;
    assign s_ua    = in_ua;
    assign s_ub    = in_ub;
    assign s_load  = in_load;
    assign s_sub   = in_sub;
  end else begin : g_noinreg
    assign s_valid = valid_i;
    assign s_a     = a_i;
    assign s_b     = b_i;
    assign s_ua    = unsigned_a_i;
    assign s_ub    = unsigned_b_i;
    assign s_load  = load_acc_i;
    assign s_sub   = subtract_i;
  end

  logic mul_valid;
  logic mul_load;
  logic mul_sub;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mul_valid <= 1'b0;
      mul_load  <= 1'b0;
      mul_sub   <= 1'b0;
      valid_o   <= 1'b0;
    end else if (en) begin
      mul_valid <= s_valid;
      mul_load  <= s_load;
      mul_sub   <= s_sub;
      valid_o   <= mul_valid;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [A_WIDTH:0]      ax;
    logic signed [B_WIDTH:0]      bx;
    logic signed [PW-1:0]         prod;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic                         ovf;
    logic signed [RW-1:0]         base;
    logic signed [RW-1:0]         result;
    logic                         ovf_now;
    logic [ACC_WIDTH-1:0]         acc_next;

    // One extra bit lets signed and unsigned operands share a single signed multiplier.
    assign ax = $signed({~s_ua & s_a[k*A_WIDTH+A_WIDTH-1], s_a[k*A_WIDTH +: A_WIDTH]});
    assign bx = $signed({~s_ub & s_b[k*B_WIDTH+B_WIDTH-1], s_b[k*B_WIDTH +: B_WIDTH]});

    always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        prod <= '0;
      end else if (en) begin
        prod <= PW'(ax) * PW'(bx);
      end
    end

    always_comb begin
      base     = (mul_load && !clear_i) ? RW'(acc) : '0;
      result   = mul_sub ? (base - RW'(prod)) : (base + RW'(prod));
      ovf_now  = (result[RW-1:ACC_WIDTH-1] != '0) && (result[RW-1:ACC_WIDTH-1] != '1);
`ifdef DSP_SIMD_MAC_SATURATE_EN
      if (ovf_now) begin
        acc_next = result[RW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
        acc_next = result[ACC_WIDTH-1:0];
      end
`else
      acc_next = result[ACC_WIDTH-1:0];
`endif
    end

    // Bubbles leave the accumulator alone unless a clear arrives with them.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (en) begin
        if (mul_valid) begin
          acc <= acc_next;
          ovf <= (ovf & ~clear_i) | ovf_now;
        end else if (clear_i) begin
          acc <= '0;
          ovf <= 1'b0;
        end
      end
    end

    assign z_o[k*ACC_WIDTH +: ACC_WIDTH] = acc >>> SHIFT_RIGHT;
    assign overflow_o[k]                 = ovf;
  end

endmodule
